// File: rtl/mem_master_pkg.sv
// Shared types and default widths for the mem_master request path.
package mem_master_pkg;

  localparam int MM_ADDR_W  = 5;
  localparam int MM_DATA_W  = 16;
  localparam int MM_DEPTH   = 4;
  localparam int MM_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic                 we;
    logic [MM_ADDR_W-1:0] addr;
    logic [MM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO; pointers carry a wrap bit so full/empty need no counter.
module mem_req_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  // Status flags, gated handshakes and head-of-queue read.
  always_comb begin
    o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    o_empty   = (r_wr_ptr == r_rd_ptr);
    w_push_ok = i_push && !o_full;
    w_pop_ok  = i_pop && !o_empty;
    o_head    = r_mem[r_rd_ptr[PTR_W-1:0]];
  end

  // Pointer and storage update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {(PTR_W+1){1'b0}};
      r_rd_ptr <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
        r_wr_ptr                   <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/mem_master.sv
// In-order initiator for the memread/memwrite/mem_done wait-state memory handshake.
// Define MEM_MASTER_TIMEOUT_EN to add the REQ watchdog, abort response and DRAIN state.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_W  = MM_ADDR_W,
  parameter int DATA_W  = MM_DATA_W,
  parameter int DEPTH   = MM_DEPTH,
  parameter int TIMEOUT = MM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              memread,
  output logic              memwrite,
  input  logic [DATA_W-1:0] rdata,
  input  logic              mem_done
);

  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_load;
  logic [ENTRY_W-1:0] w_push_entry;
  logic [ENTRY_W-1:0] w_head;
  logic               w_head_we;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [DATA_W-1:0]  w_head_wdata;

  state_e             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_memread;
  logic               r_memwrite;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_rdata;

`ifdef MEM_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]   r_cnt;
  logic               r_rsp_err;
  logic               w_cnt_last;
`endif

  assign w_push_entry = {req_we, req_addr, req_wdata};
  assign {w_head_we, w_head_addr, w_head_wdata} = w_head;

  mem_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Handshake decode; a same-edge mem_done wins over the watchdog.
  always_comb begin
    w_push = req_valid && !w_full;
    w_load = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_GAP));
`ifdef MEM_MASTER_TIMEOUT_EN
    w_cnt_last = (r_cnt == CNT_LAST);
    w_pop      = (r_state == ST_REQ) && (mem_done || w_cnt_last);
`else
    w_pop      = (r_state == ST_REQ) && mem_done;
`endif
  end

  // Transaction FSM with registered memory strobes and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= {ADDR_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_memread   <= 1'b0;
      r_memwrite  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
`ifdef MEM_MASTER_TIMEOUT_EN
      r_cnt       <= {CNT_W{1'b0}};
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
`ifdef MEM_MASTER_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
`endif
      if (w_load) begin
        r_addr     <= w_head_addr;
        r_wdata    <= w_head_wdata;
        r_memread  <= !w_head_we;
        r_memwrite <= w_head_we;
        r_state    <= ST_REQ;
`ifdef MEM_MASTER_TIMEOUT_EN
        r_cnt      <= {CNT_W{1'b0}};
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_REQ: begin
            if (mem_done) begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= r_memwrite ? {DATA_W{1'b0}} : rdata;
              r_memread   <= 1'b0;
              r_memwrite  <= 1'b0;
              r_state     <= ST_GAP;
            end
`ifdef MEM_MASTER_TIMEOUT_EN
            else if (w_cnt_last) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= {DATA_W{1'b0}};
              r_memread   <= 1'b0;
              r_memwrite  <= 1'b0;
              r_cnt       <= {CNT_W{1'b0}};
              r_state     <= ST_DRAIN;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
`endif
          end
          ST_GAP: begin
            r_state <= ST_IDLE;
          end
`ifdef MEM_MASTER_TIMEOUT_EN
          // Give an abandoned memory access time to finish before the next strobe.
          ST_DRAIN: begin
            if (mem_done || w_cnt_last) begin
              r_state <= ST_GAP;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
`endif
          default: begin
            r_state    <= ST_IDLE;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
          end
        endcase
      end
    end
  end

  assign req_ready = !w_full;
  assign busy      = !w_empty || (r_state != ST_IDLE);
  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign memread   = r_memread;
  assign memwrite  = r_memwrite;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
`ifdef MEM_MASTER_TIMEOUT_EN
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: 9-wait-state 64x8 memory model, directed table, corner sequences, random mix.
module tb_mem_master;
  import mem_master_pkg::*;

  localparam int WAITS = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [4:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata;
  logic [4:0]  addr;
  logic [15:0] wdata;
  logic        memread, memwrite;
  logic [15:0] rdata_m;
  logic        mem_done;

  mem_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .addr(addr), .wdata(wdata), .memread(memread), .memwrite(memwrite),
    .rdata(rdata_m), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_both  = 0;
  int rsp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: done pulses WAITS edges after the strobe is first seen; stall blocks it.
  logic [7:0] mem_bytes [64];
  int         wcnt  = 0;
  logic       stall = 1'b0;
  logic       r_done = 1'b0;
  assign mem_done = r_done;

  always @(posedge clk) begin
    if ((memread || memwrite) && !r_done && !stall) begin
      if (wcnt == WAITS) begin
        r_done  <= 1'b1;
        wcnt    <= 0;
        rdata_m <= {mem_bytes[{addr, 1'b1}], mem_bytes[{addr, 1'b0}]};
        if (memwrite) begin
          mem_bytes[{addr, 1'b0}] <= wdata[7:0];
          mem_bytes[{addr, 1'b1}] <= wdata[15:8];
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      r_done <= 1'b0;
      wcnt   <= 0;
    end
  end

  // Reference model: word-level shadow memory plus in-order expected responses.
  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          acc_cyc;
    int          lat;
  } exp_t;

  logic [15:0] shadow [32];
  exp_t        expq [$];
  exp_t        mon_e;

  typedef struct {
    mem_req_t    req;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t tbl [7];

  function automatic vec_t mk(input logic we, input logic [4:0] a, input logic [15:0] d,
                              input logic [15:0] e);
    vec_t v;
    v.req.we    = we;
    v.req.addr  = a;
    v.req.wdata = d;
    v.exp_rdata = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [4:0] a, input logic [15:0] d,
                      input logic err, input int lat, input logic use_ovr,
                      input logic [15:0] ovr);
    exp_t e;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int k = 0; k < 400 && !req_ready; k++) @(negedge clk);
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL push_accept: req_ready=%0b, required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    e.acc_cyc = cyc + 1;
    e.lat     = lat;
    e.err     = err;
    if (err) e.rdata = 16'h0000;
    else if (we) begin
      e.rdata   = 16'h0000;
      shadow[a] = d;
    end else e.rdata = shadow[a];
    if (use_ovr) e.rdata = ovr;
    expq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (expq.size() == 0 && !busy) return;
      @(negedge clk);
    end
    n_tests++; n_fail++;
    $display("FAIL %s: still busy with %0d responses outstanding, required 0", nm, expq.size());
    expq.delete();
  endtask

  // Response monitor and strobe exclusivity check, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (memread && memwrite) n_both++;
      if (rsp_valid) begin
        rsp_cnt++;
        if (expq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%0h, required no response", rsp_rdata);
        end else begin
          mon_e = expq.pop_front();
          chk("rsp_rdata", {16'h0000, rsp_rdata}, {16'h0000, mon_e.rdata});
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
          if (mon_e.lat >= 0) chk("rsp_latency", cyc - mon_e.acc_cyc, mon_e.lat);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc0;
    int t0;
    logic       rw;
    logic [4:0] ra;
    for (int i = 0; i < 64; i++) mem_bytes[i] = 8'(i) ^ 8'h5A;
    mem_bytes[8'h0A] = 8'h34;
    mem_bytes[8'h0B] = 8'h12;
    for (int w = 0; w < 32; w++) shadow[w] = {8'(2*w+1) ^ 8'h5A, 8'(2*w) ^ 8'h5A};
    shadow[5] = 16'h1234;

    tbl[0] = mk(1'b0, 5'd5,  16'h0000, 16'h1234);
    tbl[1] = mk(1'b1, 5'd3,  16'hBEEF, 16'h0000);
    tbl[2] = mk(1'b0, 5'd3,  16'h0000, 16'hBEEF);
    tbl[3] = mk(1'b1, 5'd31, 16'hA5A5, 16'h0000);
    tbl[4] = mk(1'b0, 5'd31, 16'h0000, 16'hA5A5);
    tbl[5] = mk(1'b0, 5'd0,  16'h0000, 16'h5B5A);
    tbl[6] = mk(1'b0, 5'd4,  16'h0000, 16'h5352);

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 5'd0; req_wdata = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_memread", {31'd0, memread}, 32'd0);
    chk("rst_memwrite", {31'd0, memwrite}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", {16'h0, rsp_rdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed single transactions: 12-edge latency, correct strobe and address.
    for (int i = 0; i < 7; i++) begin
      push(tbl[i].req.we, tbl[i].req.addr, tbl[i].req.wdata, 1'b0, 12, 1'b1, tbl[i].exp_rdata);
      @(negedge clk);
      chk("tbl_memread", {31'd0, memread}, {31'd0, !tbl[i].req.we});
      chk("tbl_memwrite", {31'd0, memwrite}, {31'd0, tbl[i].req.we});
      chk("tbl_addr", {27'd0, addr}, {27'd0, tbl[i].req.addr});
      wait_idle("tbl_idle", 60);
    end

    // Five back-to-back requests into a four-deep FIFO.
    push(1'b1, 5'd10, 16'h1111, 1'b0, -1, 1'b0, 16'h0);
    push(1'b0, 5'd10, 16'h0000, 1'b0, -1, 1'b0, 16'h0);
    push(1'b1, 5'd11, 16'h2222, 1'b0, -1, 1'b0, 16'h0);
    push(1'b0, 5'd11, 16'h0000, 1'b0, -1, 1'b0, 16'h0);
    chk("full_ready_low", {31'd0, req_ready}, 32'd0);
    for (int k = 0; k < 40 && !rsp_valid; k++) @(negedge clk);
    chk("first_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    chk("ready_after_pop", {31'd0, req_ready}, 32'd1);
    chk("gap_strobe_low", {31'd0, memread | memwrite}, 32'd0);
    @(negedge clk);
    chk("gap_next_strobe", {31'd0, memread}, 32'd1);
    push(1'b0, 5'd5, 16'h0000, 1'b0, -1, 1'b0, 16'h0);
    wait_idle("fifo_idle", 200);

    // Reset in the middle of a REQ wait.
    push(1'b0, 5'd7, 16'h0000, 1'b0, -1, 1'b0, 16'h0);
    repeat (4) @(negedge clk);
    chk("mid_req_strobe", {31'd0, memread}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_memread", {31'd0, memread}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_addr", {27'd0, addr}, 32'd0);
    expq.delete();
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    push(1'b0, 5'd7, 16'h0000, 1'b0, 12, 1'b0, 16'h0);
    wait_idle("post_rst_idle", 60);

`ifdef MEM_MASTER_TIMEOUT_EN
    // Stalled memory: abort after 15 REQ cycles, 15-cycle DRAIN, then next request.
    stall = 1'b1;
    push(1'b0, 5'd6, 16'h0000, 1'b1, 16, 1'b0, 16'h0);
    push(1'b0, 5'd6, 16'h0000, 1'b0, -1, 1'b0, 16'h0);
    for (int k = 0; k < 60 && !rsp_valid; k++) @(negedge clk);
    chk("abort_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    t0 = cyc;
    stall = 1'b0;
    for (int k = 0; k < 60 && !memread; k++) @(negedge clk);
    chk("drain_to_next_strobe", cyc - t0, 32'd16);
    wait_idle("timeout_idle", 100);
`endif

    // Random mix on a narrow address range so reads often hit earlier writes.
    rc0 = rsp_cnt;
    for (int i = 0; i < 200; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 5'($urandom_range(0, 7));
      push(rw, ra, 16'($urandom), 1'b0, -1, 1'b0, 16'h0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    wait_idle("rand_idle", 3500);
    chk("rand_rsp_count", rsp_cnt - rc0, 32'd200);
    chk("strobe_exclusive", n_both, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_master.md
# mem_master

Initiator-side controller for the 64×8 wait-state memory's `memread`/`memwrite`/`mem_done` handshake. It accepts word read/write requests from the cache through a valid/ready port and queues them in a small FIFO. It issues them to memory strictly in order, captures read data on the completion edge, and returns one response per request. It sits between the cache controller and the memory module.

## Interface
- `ADDR_W`, 5, word address width (memory word = 2 bytes, byte address = `{addr,1'b0}`)
- `DATA_W`, 16, word width
- `DEPTH`, 4, request FIFO entries (power of two, ≥2)
- `TIMEOUT`, 15, max REQ cycles before abort (only with `MEM_MASTER_TIMEOUT_EN`)

- `clk` in 1: single clock, all state on posedge
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: FIFO not full
- `req_we` in 1: 1 = write, 0 = read
- `req_addr` in ADDR_W: word address
- `req_wdata` in DATA_W: write data
- `rsp_valid` out 1: one-cycle response pulse
- `rsp_rdata` out DATA_W: read data; 0 for writes and errors
- `rsp_err` out 1: response is an abort (timeout build only, else tied 0)
- `busy` out 1: FIFO non-empty or FSM not IDLE
- `addr` out ADDR_W: to memory
- `wdata` out DATA_W: to memory
- `memread` out 1: read strobe, registered
- `memwrite` out 1: write strobe, registered
- `rdata` in DATA_W: from memory
- `mem_done` in 1: completion, valid while strobe is held

## Operation
- Push on `req_valid && req_ready`; `req_ready = !full`. No push when full, even if a pop happens the same cycle.
- FSM states: IDLE, REQ, GAP, plus DRAIN in the timeout build.
- IDLE: if FIFO non-empty, load head into `addr`/`wdata` and set exactly one of `memread`/`memwrite` → REQ.
- REQ: hold `addr`, `wdata` and the strobe stable. When `mem_done` is sampled high:
  - pop the FIFO;
  - pulse `rsp_valid`;
  - latch `rsp_rdata <= rdata` for reads, 0 for writes;
  - clear the strobe;
  - go to GAP.
- GAP: strobes low for exactly one cycle. At the end of GAP, if FIFO non-empty, load the next head directly → REQ, else → IDLE.
- Strobes are never both high. They are never high in GAP or DRAIN.
- `mem_done` sampled outside REQ is ignored, except in DRAIN.
- Reset (any time, mid-transaction included) does the following:
  - FSM → IDLE, FIFO empty;
  - `memread = memwrite = 0`, `rsp_valid = 0`, `rsp_err = 0`;
  - `rsp_rdata = 0`, `addr = 0`, `wdata = 0`;
  - `busy = 0`, `req_ready = 1`.
- Memory-side state is not reset by this block.

## Timing
- The FIFO is registered. A request accepted at edge E0 is seen by IDLE at E1, and the strobe is high from E1.
- With 9 memory wait states:
  - memory samples the strobe at E2;
  - `mem_done` is high in the E11–E12 cycle;
  - capture happens at E12;
  - `rsp_valid` is high in the E12–E13 cycle.
- Latency: 12 edges, accept to response.
- Back-to-back: the strobe drops at E12 (GAP) and the next strobe rises at E13. Steady state is one transaction per 12 cycles.
- `rsp_valid` is a single-cycle pulse, with no backpressure. Responses come out in request order.

## Configuration
- `MEM_MASTER_TIMEOUT_EN` defined:
  - A counter clears on REQ entry and increments each REQ cycle.
  - On reaching `TIMEOUT` with no `mem_done`: pop, pulse `rsp_valid` with `rsp_err = 1` and `rsp_rdata = 0`, drop the strobe, go to DRAIN.
  - DRAIN waits for a `mem_done` pulse or another `TIMEOUT` cycles, then goes to GAP.
  - `mem_done` arriving on the same edge as the timeout counts as success.
- Undefined: no counter and no DRAIN state; REQ waits indefinitely; `rsp_err` is tied 0.

## Structure
- Package `mem_master_pkg` holds:
  - the state enum (IDLE, REQ, GAP, DRAIN);
  - the FIFO entry struct {we, addr, wdata};
  - default width constants.
- Sub-module `mem_req_fifo`: parameterised synchronous FIFO with async active-low reset. It provides push/pop, full/empty and head outputs, using pointers with a wrap bit.

## Test plan
- Single read of addr 5 (memory bytes 0x0A=0x34, 0x0B=0x12) → `memread` high E1–E12; `rsp_valid` at E12 with `rsp_rdata` = 0x1234, `rsp_err` = 0.
- Write 0xBEEF to addr 3, then read addr 3 → write ack (`rsp_rdata` = 0); read returns 0xBEEF; one-cycle strobe gap between transactions.
- Push 5 requests back-to-back with `DEPTH` = 4 → `req_ready` low after 4 accepts, high again the cycle after the first pop; all 5 responses in order.
- Assert `rst_n` low while in REQ, mid-wait → strobes and `busy` go 0 immediately, FIFO empties, no `rsp_valid`; a new request after reset completes normally.
- Timeout build, memory `mem_done` forced low → `rsp_valid` with `rsp_err` = 1 after 15 REQ cycles, DRAIN for 15 cycles, the next queued request is then issued.
- Random mix of 200 reads/writes against a reference model → every read matches the last write to that address; strobes are never both high.
